// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock's period in clk_in cycles and tracks lock, period errors and loss of clock.
// Optional high-time check is built when CLK_MON_DUTY_EN is defined; otherwise duty_err is tied 0.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 12,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 48,
  parameter int EXP_HIGH   = 6
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mon_clk,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err_pulse,
  output logic             lost_pulse,
  output logic             duty_err
);
  localparam logic [1:0] IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0] EXP_P = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] TOL_P = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0] TO_P = (CNT_W+1)'(TIMEOUT);
  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  logic s1, s2, s3, rise, good, timeout, ok, duty_bad;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0] meas, diff;
  logic [1:0] state;
  logic [3:0] good_cnt;
  assign rise = s2 & ~s3;
  assign meas = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign diff = meas >= EXP_P ? meas - EXP_P : EXP_P - meas;
  assign good = diff <= TOL_P;
  assign timeout = ~rise & (meas >= TO_P);
  assign ok = good & ~duty_bad;
  // bring mon_clk into the clk_in domain and keep one extra stage for edge detection
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {mon_clk, s1, s2};
  // rise-to-rise counter; period latches the count on every rise while enabled
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      period <= '0;
    end else if (!en) cnt_q <= '0;
    else if (rise) begin
      cnt_q <= '0;
      period <= meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
    end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
  // lock FSM with its event pulses; the first rise out of IDLE is only a starting point
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      good_cnt <= '0;
      locked <= 1'b0;
      period_vld <= 1'b0;
      err_pulse <= 1'b0;
      lost_pulse <= 1'b0;
    end else begin
      period_vld <= en & rise & (state != IDLE);
      err_pulse <= en & rise & (state != IDLE) & ~ok;
      lost_pulse <= en & timeout & (state != IDLE);
      if (!en) begin
        state <= IDLE;
        good_cnt <= '0;
        locked <= 1'b0;
      end else if (state == IDLE) begin
        if (rise) begin
          state <= ACQ;
          good_cnt <= '0;
        end
      end else if (rise & ~ok) begin
        state <= ACQ;
        good_cnt <= '0;
        locked <= 1'b0;
      end else if (rise & (state == ACQ)) begin
        if (good_cnt + 4'd1 == LOCK_C) begin
          state <= LOCKED;
          locked <= 1'b1;
        end else good_cnt <= good_cnt + 4'd1;
      end else if (timeout) begin
        state <= IDLE;
        locked <= 1'b0;
      end
    end
`ifdef CLK_MON_DUTY_EN
  localparam logic [CNT_W:0] HI_P = (CNT_W+1)'(EXP_HIGH);
  logic fall, fell_q;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W:0] hi_meas, hi_diff;
  assign fall = ~s2 & s3;
  assign hi_diff = hi_meas >= HI_P ? hi_meas - HI_P : HI_P - hi_meas;
  assign duty_bad = ~fell_q | (hi_diff > TOL_P);
  // high-time counter; a rise with no fall since the previous rise is itself a violation
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      hi_q <= '0;
      hi_meas <= '0;
      fell_q <= 1'b0;
      duty_err <= 1'b0;
    end else begin
      duty_err <= en & rise & (state != IDLE) & duty_bad;
      if (rise) begin
        hi_q <= '0;
        fell_q <= 1'b0;
      end else begin
        if (s2 && hi_q != CNT_MAX) hi_q <= hi_q + CNT_W'(1);
        if (fall) begin
          hi_meas <= {1'b0, hi_q} + (CNT_W+1)'(1);
          fell_q <= 1'b1;
        end
      end
    end
`else
  localparam int unused_exp_high = EXP_HIGH;
  assign duty_bad = 1'b0;
  assign duty_err = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: randomized scoreboard bench for clk_div_monitor against a period-level lock model
module tb_clk_div_monitor;
  localparam int EXPP = 12, TOL = 1, LOCK_CNT = 4, TIMEOUT = 48, EXP_HIGH = 6;
  typedef struct {bit vld; bit err; bit lost; bit de; bit lk; int per;} ev_t;
  logic clk_in = 0, reset_n = 0, en = 0, mon_clk = 0;
  logic locked, period_vld, err_pulse, lost_pulse, duty_err;
  logic [7:0] period;
  int checks = 0, failures = 0;
  ev_t q[$];
  int m_state = 0, m_good = 0, prev_p = 0, prev_h = 0;
  bit m_lk = 0;
  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(EXPP), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
                    .TIMEOUT(TIMEOUT), .EXP_HIGH(EXP_HIGH)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .mon_clk(mon_clk), .locked(locked),
    .period(period), .period_vld(period_vld), .err_pulse(err_pulse),
    .lost_pulse(lost_pulse), .duty_err(duty_err));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  // one mon_clk period: rising edge, h cycles high, p-h cycles low
  task automatic item(input int p, input int h);
    ev_t e;
    if (m_state == 0) begin
      m_state = 1;
      m_good = 0;
    end else begin
      bit pg, db, ok;
      pg = (prev_p > EXPP ? prev_p - EXPP : EXPP - prev_p) <= TOL;
      db = 0;
`ifdef CLK_MON_DUTY_EN
      db = (prev_h > EXP_HIGH ? prev_h - EXP_HIGH : EXP_HIGH - prev_h) > TOL;
`endif
      ok = pg && !db;
      if (!ok) begin
        m_state = 1;
        m_good = 0;
        m_lk = 0;
      end else if (m_state == 1) begin
        m_good++;
        if (m_good == LOCK_CNT) begin
          m_state = 2;
          m_lk = 1;
        end
      end
      e = '{1, !ok, 0, db, m_lk, prev_p};
      q.push_back(e);
    end
    if (p > TIMEOUT) begin
      m_state = 0;
      m_lk = 0;
      e = '{0, 0, 1, 0, 0, 0};
      q.push_back(e);
    end
    prev_p = p;
    prev_h = h;
    mon_clk = 1;
    repeat (h) @(negedge clk_in);
    mon_clk = 0;
    repeat (p - h) @(negedge clk_in);
  endtask
  // en low for 3 cycles during a low phase; monitor restarts from IDLE
  task automatic en_drop();
    repeat (2) @(negedge clk_in);
    en = 0;
    @(negedge clk_in);
    chk("locked_after_en_drop", locked, 0);
    repeat (2) @(negedge clk_in);
    en = 1;
    m_state = 0;
    m_lk = 0;
    repeat (3) @(negedge clk_in);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk_in);
    chk(name, q.size(), 0);
  endtask
  // scoreboard monitor: every output event pops one expected event
  always @(negedge clk_in) begin
    if (reset_n && (period_vld || err_pulse || lost_pulse || duty_err)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event vld=%b err=%b lost=%b duty=%b period=%0d", period_vld,
                 err_pulse, lost_pulse, duty_err, period);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (period_vld !== e.vld || err_pulse !== e.err || lost_pulse !== e.lost ||
            duty_err !== e.de || locked !== e.lk || (e.vld && period != 8'(e.per))) begin
          failures++;
          $display("FAIL event got vld/err/lost/duty/lk=%b%b%b%b%b period=%0d expected=%b%b%b%b%b period=%0d",
                   period_vld, err_pulse, lost_pulse, duty_err, locked, period,
                   e.vld, e.err, e.lost, e.de, e.lk, e.per);
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk_in);
    chk("reset_locked", locked, 0);
    chk("reset_period", period, 0);
    chk("reset_vld", period_vld, 0);
    chk("reset_err", err_pulse, 0);
    chk("reset_lost", lost_pulse, 0);
    chk("reset_duty", duty_err, 0);
    reset_n = 1;
    en = 1;
    repeat (2) @(negedge clk_in);
    repeat (6) item(12, 6);
    item(15, 7);
    repeat (5) item(12, 6);
    repeat (3) begin item(11, 5); item(13, 6); end
    item(48, 6);
    repeat (5) item(12, 6);
    item(49, 6);
    repeat (6) item(12, 6);
    en_drop();
    repeat (6) item(12, 6);
    repeat (6) item(12, 9);
    repeat (6) item(12, 6);
    drain("drain_directed");
    chk("locked_directed", locked, m_lk);
    for (int n = 0; n < 90; n++) begin
      int r, p, h;
      r = $urandom_range(0, 19);
      if (r == 18 && (m_state == 0 || prev_p <= 40)) en_drop();
      else begin
        if (r < 12) p = $urandom_range(11, 13);
        else if (r < 14) p = $urandom_range(9, 10);
        else if (r < 16) p = $urandom_range(14, 30);
        else if (r < 18) p = $urandom_range(44, 60);
        else p = $urandom_range(48, 49);
        h = p < 14 ? $urandom_range(5, 7) : 6;
        item(p, h);
      end
    end
    item(60, 6);
    drain("drain_random");
    chk("locked_after_loss", locked, 0);
    repeat (6) item(12, 6);
    drain("drain_relock");
    chk("relocked", locked, 1);
    #3 reset_n = 0;
    #1;
    chk("midrun_reset_locked", locked, 0);
    chk("midrun_reset_period", period, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receiving-side checker for divided clocks produced by the peripheral clock dividers.
- Runs in the fast source domain and samples the divided clock as an asynchronous input.
- Measures the divided clock's period in source-clock cycles and declares lock after consecutive in-tolerance periods.
- Flags period errors and loss of clock; firmware and the accelerator's clock gating use `locked` to trust the slow domain.

Parameters:
- CNT_W, 8: width of period counter and period output.
- EXP_PERIOD, 12: expected divided-clock period in clk_in cycles; must be >= 4.
- TOL, 1: allowed absolute deviation from EXP_PERIOD, inclusive.
- LOCK_CNT, 4: consecutive good periods required to assert locked; range 1..15.
- TIMEOUT, 48: cycles without a rising edge before loss is declared; must be > EXP_PERIOD+TOL and <= 2^CNT_W-1.
- EXP_HIGH, 6: expected high time in clk_in cycles; used only with CLK_MON_DUTY_EN.

Ports:
- clk_in  input  1  source clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  monitor enable, synchronous to clk_in.
- mon_clk  input  1  divided clock under test, asynchronous to clk_in.
- locked  output  1  level; lock state reached.
- period  output  CNT_W  last measured period.
- period_vld  output  1  one-cycle pulse when period updates.
- err_pulse  output  1  one-cycle pulse on an out-of-tolerance period.
- lost_pulse  output  1  one-cycle pulse on timeout.
- duty_err  output  1  one-cycle pulse on a duty violation; tied 0 without the macro.

Behaviour:
- Reset: all outputs 0. Synchronizer flops, cnt_q, good_cnt = 0. State = IDLE.
- Sync and edge detect:
  - mon_clk passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
  - rise = s2 & ~s3. fall = ~s2 & s3.
  - rise is seen 2–3 clk_in cycles after the mon_clk edge.
- Period counter, every cycle:
  - If rise: period <= cnt_q+1; cnt_q <= 0; period_vld = 1 unless state is IDLE.
  - Otherwise cnt_q <= cnt_q+1, saturating at 2^CNT_W-1.
  - Example: mon_clk period of 12 cycles gives period = 12.
- good = |period_meas − EXP_PERIOD| <= TOL, where period_meas = cnt_q+1. Compute in CNT_W+1 bits; no wrap.
- timeout = ~rise & (cnt_q+1 >= TIMEOUT).
- FSM states IDLE, ACQ, LOCKED:
  - IDLE: on the first rise go to ACQ with good_cnt=0. The first edge is not measured. No pulses are generated.
  - ACQ, rise & good: good_cnt++. When good_cnt+1 == LOCK_CNT, go to LOCKED and set locked=1 on the next cycle.
  - ACQ, rise & ~good: err_pulse; good_cnt=0; stay in ACQ.
  - LOCKED, rise & ~good: err_pulse; locked=0; good_cnt=0; go to ACQ.
  - ACQ or LOCKED, timeout: lost_pulse; locked=0; go to IDLE.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins and timeout is suppressed.
  - en=0 has priority over everything. Next cycle: IDLE, locked=0, good_cnt=0, cnt_q=0, no pulses. period holds its value. Synchronizer keeps running.
- Reset asserted mid-operation: immediate return to reset values.
- All outputs are registered. Pulses last exactly one cycle.

Optional Feature:
- Macro: CLK_MON_DUTY_EN.
- Defined:
  - High counter hi_q clears on rise and increments while s2=1, saturating.
  - On fall, hi_q+1 is latched into hi_meas.
  - On the next rise (state ACQ or LOCKED), |hi_meas − EXP_HIGH| > TOL pulses duty_err and counts as not good, with the same FSM effect as a bad period.
  - If no fall occurred since the previous rise, this is a duty violation.
- Undefined: no high counter; duty_err tied 0.

Test Plan:
- Reset, en=1, mon_clk period 12 (high 6) → period_vld with period=12 each edge; locked=1 after the 5th rise (first plus 4 good); err/lost never pulse.
- Locked, one mon_clk period of 15 → err_pulse once, period=15, locked drops next cycle; relocks after 4 further good periods.
- Periods alternating 11/13 (TOL=1) → all good, locked=1 after 5 rises.
- Locked, mon_clk held low → lost_pulse 48 cycles after the last rise, locked=0, state IDLE; on restart the first rise gives no period_vld.
- en dropped for 3 cycles while locked → locked=0 next cycle, no pulses; after en=1, lock is reacquired.
- CLK_MON_DUTY_EN with period 12 and high 9 → duty_err and err-path behaviour on each rise; locked never asserts. Without the macro, the same stimulus locks.
